dmem_arbiter: RTL

//   Shares the single combinational data memory between two requesters: port 0 is the core load/store path, port 1 is the program loader / DMA path.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single combinational data memory: round-robin
// grants with optional locked bursts, and a registered response one cycle after each beat.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_write_0,
    input  logic              req_lock_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              req_ready_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    input  logic              req_valid_1,
    input  logic              req_write_1,
    input  logic              req_lock_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              req_ready_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [1:0]        dbg_state
);

    // Handshake: a beat on port N transfers in the cycle req_valid_N && req_ready_N;
    // the requester holds its request stable until then, and its response follows one cycle later.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    state_t           state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, cnt_nxt, cnt_inc;
    logic             grant_0, grant_1;
    logic             gnt_write, gnt_lock;

    always_comb begin
        grant_0   = 1'b0;
        grant_1   = 1'b0;
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = burst_cnt;
        cnt_inc   = burst_cnt + 1'b1;
        gnt_write = 1'b0;
        gnt_lock  = 1'b0;

        if (!reset) begin
            unique case (state)
                IDLE: begin
                    // last records the most recent winner, so a tie goes to the other port
                    if (req_valid_0 && (!req_valid_1 || last))
                        grant_0 = 1'b1;
                    else if (req_valid_1)
                        grant_1 = 1'b1;
                end
                LOCK0:   grant_0 = req_valid_0;
                LOCK1:   grant_1 = req_valid_1;
                default: ;
            endcase
        end

        if (grant_0) begin
            gnt_write = req_write_0;
            gnt_lock  = req_lock_0;
        end else if (grant_1) begin
            gnt_write = req_write_1;
            gnt_lock  = req_lock_1;
        end

        if (grant_0 || grant_1) begin
            last_nxt = grant_1;
            if (gnt_lock && (cnt_inc < BURST_LIMIT)) begin
                state_nxt = grant_1 ? LOCK1 : LOCK0;
                cnt_nxt   = cnt_inc;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end else if (state != IDLE) begin
            // owner went idle: release the lock rather than stall the other port
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        if (grant_0) begin
            mem_address    = req_addr_0;
            mem_write_data = req_wdata_0;
        end else if (grant_1) begin
            mem_address    = req_addr_1;
            mem_write_data = req_wdata_1;
        end
    end

    assign mem_write   = gnt_write;
    assign mem_read    = (grant_0 || grant_1) && !gnt_write;
    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            burst_cnt   <= '0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_rdata_1 <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            burst_cnt   <= cnt_nxt;
            rsp_valid_0 <= grant_0;
            rsp_valid_1 <= grant_1;
            if (grant_0)
                rsp_rdata_0 <= req_write_0 ? '0 : mem_read_data;
            if (grant_1)
                rsp_rdata_1 <= req_write_1 ? '0 : mem_read_data;
        end
    end

endmodule
